// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control FSM sharing one memory port between fetch and data access.
// Outputs are decoded from the state register; memory states stall until i_mem_ready.
module mc_control_unit #(
  parameter int OP_CODE_WIDTH = 7,
  parameter int FUNCT3_WIDTH  = 3,
  parameter int FUNCT7_WIDTH  = 7,
  parameter int ALU_OP_WIDTH  = 4,
  parameter bit TRAP_HALT     = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [OP_CODE_WIDTH-1:0] i_op_code,
  input  logic [FUNCT3_WIDTH-1:0]  i_funct3,
  input  logic [FUNCT7_WIDTH-1:0]  i_funct7,
  input  logic                     i_alu_zero_flag,
  input  logic                     i_mem_ready,
  output logic                     o_mem_req,
  output logic                     o_mem_wr_en,
  output logic                     o_adr_src,
  output logic                     o_ir_wr_en,
  output logic                     o_pc_wr_en,
  output logic [1:0]               o_alu_src_a,
  output logic [1:0]               o_alu_src_b,
  output logic [ALU_OP_WIDTH-1:0]  o_alu_op,
  output logic [2:0]               o_imm_sel,
  output logic                     o_reg_file_wr_en,
  output logic [1:0]               o_wb_result_sel,
  output logic                     o_instr_commit,
  output logic                     o_illegal_instr
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_LUI, S_ALU_WB, S_JAL, S_JALR, S_LINK, S_BRANCH, S_TRAP
  } state_e;

  localparam logic [OP_CODE_WIDTH-1:0] OPC_LOAD   = OP_CODE_WIDTH'(7'b0000011);
  localparam logic [OP_CODE_WIDTH-1:0] OPC_STORE  = OP_CODE_WIDTH'(7'b0100011);
  localparam logic [OP_CODE_WIDTH-1:0] OPC_R      = OP_CODE_WIDTH'(7'b0110011);
  localparam logic [OP_CODE_WIDTH-1:0] OPC_I      = OP_CODE_WIDTH'(7'b0010011);
  localparam logic [OP_CODE_WIDTH-1:0] OPC_JAL    = OP_CODE_WIDTH'(7'b1101111);
  localparam logic [OP_CODE_WIDTH-1:0] OPC_JALR   = OP_CODE_WIDTH'(7'b1100111);
  localparam logic [OP_CODE_WIDTH-1:0] OPC_BRANCH = OP_CODE_WIDTH'(7'b1100011);
  localparam logic [OP_CODE_WIDTH-1:0] OPC_LUI    = OP_CODE_WIDTH'(7'b0110111);

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD    = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB    = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND    = ALU_OP_WIDTH'(2);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR     = ALU_OP_WIDTH'(3);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR    = ALU_OP_WIDTH'(4);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL    = ALU_OP_WIDTH'(5);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL    = ALU_OP_WIDTH'(6);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA    = ALU_OP_WIDTH'(7);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT    = ALU_OP_WIDTH'(8);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU   = ALU_OP_WIDTH'(9);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_PASS_B = ALU_OP_WIDTH'(10);

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic [ALU_OP_WIDTH-1:0] arith_op, br_op;
  logic   br_taken, r_ok, br_ok;

  // funct7[5] selects SUB/SRA; the I-type path overrides funct3=000 to ADD.
  always_comb begin
    arith_op = ALU_ADD;
    case (i_funct3)
      3'b000:  arith_op = i_funct7[5] ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = i_funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  end

  always_comb begin
    br_op    = ALU_SUB;
    br_taken = 1'b0;
    case (i_funct3)
      3'b000:  begin br_op = ALU_SUB;  br_taken =  i_alu_zero_flag; end
      3'b001:  begin br_op = ALU_SUB;  br_taken = !i_alu_zero_flag; end
      3'b100:  begin br_op = ALU_SLT;  br_taken = !i_alu_zero_flag; end
      3'b101:  begin br_op = ALU_SLT;  br_taken =  i_alu_zero_flag; end
      3'b110:  begin br_op = ALU_SLTU; br_taken = !i_alu_zero_flag; end
      3'b111:  begin br_op = ALU_SLTU; br_taken =  i_alu_zero_flag; end
      default: begin br_op = ALU_SUB;  br_taken = 1'b0; end
    endcase
  end

  assign r_ok  = (i_funct7 == 7'h00) ||
                 ((i_funct7 == 7'h20) && ((i_funct3 == 3'b000) || (i_funct3 == 3'b101)));
  assign br_ok = (i_funct3 != 3'b010) && (i_funct3 != 3'b011);

  always_comb begin
    state_d          = state_q;
    o_mem_req        = 1'b0;
    o_mem_wr_en      = 1'b0;
    o_adr_src        = 1'b0;
    o_ir_wr_en       = 1'b0;
    o_pc_wr_en       = 1'b0;
    o_alu_src_a      = 2'd0;
    o_alu_src_b      = 2'd0;
    o_alu_op         = ALU_ADD;
    o_imm_sel        = IMM_I;
    o_reg_file_wr_en = 1'b0;
    o_wb_result_sel  = 2'd0;
    o_instr_commit   = 1'b0;
    case (state_q)
      S_FETCH: begin
        o_mem_req       = 1'b1;
        o_alu_src_b     = 2'd2;
        o_wb_result_sel = 2'd2;
        o_ir_wr_en      = i_mem_ready;
        o_pc_wr_en      = i_mem_ready;
        if (i_mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        o_alu_src_a = 2'd1;
        o_alu_src_b = 2'd1;
        o_imm_sel   = (i_op_code == OPC_JAL) ? IMM_J : IMM_B;
        case (i_op_code)
          OPC_LOAD, OPC_STORE: state_d = S_MEM_ADDR;
          OPC_R:               state_d = r_ok ? S_EXEC_R : S_TRAP;
          OPC_I:               state_d = S_EXEC_I;
          OPC_JAL:             state_d = S_JAL;
          OPC_JALR:            state_d = S_JALR;
          OPC_BRANCH:          state_d = br_ok ? S_BRANCH : S_TRAP;
          OPC_LUI:             state_d = S_LUI;
          default:             state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        o_alu_src_a = 2'd2;
        o_alu_src_b = 2'd1;
        o_imm_sel   = (i_op_code == OPC_STORE) ? IMM_S : IMM_I;
        state_d     = (i_op_code == OPC_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        o_mem_req = 1'b1;
        o_adr_src = 1'b1;
        if (i_mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        o_reg_file_wr_en = 1'b1;
        o_wb_result_sel  = 2'd1;
        o_instr_commit   = 1'b1;
        state_d          = S_FETCH;
      end
      S_MEM_WRITE: begin
        o_mem_req      = 1'b1;
        o_mem_wr_en    = 1'b1;
        o_adr_src      = 1'b1;
        o_instr_commit = i_mem_ready;
        if (i_mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        o_alu_src_a = 2'd2;
        o_alu_op    = arith_op;
        state_d     = S_ALU_WB;
      end
      S_EXEC_I: begin
        o_alu_src_a = 2'd2;
        o_alu_src_b = 2'd1;
        o_alu_op    = (i_funct3 == 3'b000) ? ALU_ADD : arith_op;
        state_d     = S_ALU_WB;
      end
      S_LUI: begin
        o_alu_src_b = 2'd1;
        o_imm_sel   = IMM_U;
        o_alu_op    = ALU_PASS_B;
        state_d     = S_ALU_WB;
      end
      S_ALU_WB: begin
        o_reg_file_wr_en = 1'b1;
        o_instr_commit   = 1'b1;
        state_d          = S_FETCH;
      end
      S_JAL: begin
        // Jump target was computed during DECODE and sits in ALUOut.
        o_pc_wr_en = 1'b1;
        state_d    = S_LINK;
      end
      S_JALR: begin
        o_alu_src_a     = 2'd2;
        o_alu_src_b     = 2'd1;
        o_pc_wr_en      = 1'b1;
        o_wb_result_sel = 2'd2;
        state_d         = S_LINK;
      end
      S_LINK: begin
        o_alu_src_a      = 2'd1;
        o_alu_src_b      = 2'd2;
        o_reg_file_wr_en = 1'b1;
        o_wb_result_sel  = 2'd2;
        o_instr_commit   = 1'b1;
        state_d          = S_FETCH;
      end
      S_BRANCH: begin
        o_alu_src_a    = 2'd2;
        o_alu_op       = br_op;
        o_pc_wr_en     = br_taken;
        o_instr_commit = 1'b1;
        state_d        = S_FETCH;
      end
      S_TRAP: begin
        state_d = TRAP_HALT ? S_TRAP : S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (i_reset) begin
      o_mem_req        = 1'b0;
      o_mem_wr_en      = 1'b0;
      o_adr_src        = 1'b0;
      o_ir_wr_en       = 1'b0;
      o_pc_wr_en       = 1'b0;
      o_alu_src_a      = 2'd0;
      o_alu_src_b      = 2'd0;
      o_alu_op         = ALU_ADD;
      o_imm_sel        = IMM_I;
      o_reg_file_wr_en = 1'b0;
      o_wb_result_sel  = 2'd0;
      o_instr_commit   = 1'b0;
    end
  end

  assign illegal_d       = illegal_q || (state_d == S_TRAP);
  assign o_illegal_instr = illegal_q && !i_reset;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: one halting and one skipping instance share stimulus;
// every control output is packed into a vector and compared per cycle against hand-built values.
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] f3 = 3'd0;
  logic [6:0] f7 = 7'd0;
  logic       zero = 1'b0;
  logic       ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic       h_mem_req, h_mem_wr_en, h_adr_src, h_ir_wr_en, h_pc_wr_en;
  logic [1:0] h_alu_src_a, h_alu_src_b, h_wb_result_sel;
  logic [3:0] h_alu_op;
  logic [2:0] h_imm_sel;
  logic       h_reg_file_wr_en, h_instr_commit, h_illegal_instr;

  logic       s_mem_req, s_mem_wr_en, s_adr_src, s_ir_wr_en, s_pc_wr_en;
  logic [1:0] s_alu_src_a, s_alu_src_b, s_wb_result_sel;
  logic [3:0] s_alu_op;
  logic [2:0] s_imm_sel;
  logic       s_reg_file_wr_en, s_instr_commit, s_illegal_instr;

  mc_control_unit #(.TRAP_HALT(1'b1)) dut_h (
    .i_clk(clk), .i_reset(reset), .i_op_code(op), .i_funct3(f3), .i_funct7(f7),
    .i_alu_zero_flag(zero), .i_mem_ready(ready),
    .o_mem_req(h_mem_req), .o_mem_wr_en(h_mem_wr_en), .o_adr_src(h_adr_src),
    .o_ir_wr_en(h_ir_wr_en), .o_pc_wr_en(h_pc_wr_en), .o_alu_src_a(h_alu_src_a),
    .o_alu_src_b(h_alu_src_b), .o_alu_op(h_alu_op), .o_imm_sel(h_imm_sel),
    .o_reg_file_wr_en(h_reg_file_wr_en), .o_wb_result_sel(h_wb_result_sel),
    .o_instr_commit(h_instr_commit), .o_illegal_instr(h_illegal_instr)
  );

  mc_control_unit #(.TRAP_HALT(1'b0)) dut_s (
    .i_clk(clk), .i_reset(reset), .i_op_code(op), .i_funct3(f3), .i_funct7(f7),
    .i_alu_zero_flag(zero), .i_mem_ready(ready),
    .o_mem_req(s_mem_req), .o_mem_wr_en(s_mem_wr_en), .o_adr_src(s_adr_src),
    .o_ir_wr_en(s_ir_wr_en), .o_pc_wr_en(s_pc_wr_en), .o_alu_src_a(s_alu_src_a),
    .o_alu_src_b(s_alu_src_b), .o_alu_op(s_alu_op), .o_imm_sel(s_imm_sel),
    .o_reg_file_wr_en(s_reg_file_wr_en), .o_wb_result_sel(s_wb_result_sel),
    .o_instr_commit(s_instr_commit), .o_illegal_instr(s_illegal_instr)
  );

  logic [20:0] vh, vs;
  assign vh = {h_mem_req, h_mem_wr_en, h_adr_src, h_ir_wr_en, h_pc_wr_en, h_alu_src_a,
               h_alu_src_b, h_alu_op, h_imm_sel, h_reg_file_wr_en, h_wb_result_sel,
               h_instr_commit, h_illegal_instr};
  assign vs = {s_mem_req, s_mem_wr_en, s_adr_src, s_ir_wr_en, s_pc_wr_en, s_alu_src_a,
               s_alu_src_b, s_alu_op, s_imm_sel, s_reg_file_wr_en, s_wb_result_sel,
               s_instr_commit, s_illegal_instr};

  // Field order: mem_req wr_en adr_src ir_wr pc_wr src_a src_b alu_op imm_sel reg_wr wb_sel commit illegal
  function automatic logic [20:0] pk(input int mr, input int wr, input int adr, input int ir,
                                     input int pc, input int sa, input int sb, input int aop,
                                     input int imm, input int rw, input int wb, input int cm,
                                     input int il);
    return {1'(mr), 1'(wr), 1'(adr), 1'(ir), 1'(pc), 2'(sa), 2'(sb), 4'(aop), 3'(imm),
            1'(rw), 2'(wb), 1'(cm), 1'(il)};
  endfunction

  logic [20:0] F_RDY, F_WAIT, DEC_B, DEC_J, AWB, LINKV, ILL, MA_L, MA_S, MR, MWB, MW_WAIT, MW_RDY;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ready = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if (vh !== 21'd0) begin errors++; $display("FAIL reset_h: got %h exp %h", vh, 21'd0); end
    checks++;
    if (vs !== 21'd0) begin errors++; $display("FAIL reset_s: got %h exp %h", vs, 21'd0); end
    reset = 1'b0;
    ready = 1'b0;
    #1;
    checks++;
    if (vh !== F_WAIT) begin errors++; $display("FAIL reset_release: got %h exp %h", vh, F_WAIT); end
    tick();
    checks++;
    if (vh !== F_WAIT) begin errors++; $display("FAIL fetch_wait_hold: got %h exp %h", vh, F_WAIT); end
  endtask

  task automatic test_alu_ops();
    logic [37:0] tbl [11];
    logic [20:0] e;
    int ncm;
    tbl = '{
      {7'b0110011, 3'b000, 7'h00, pk(0,0,0,0,0,2,0,0,0,0,0,0,0)},
      {7'b0110011, 3'b000, 7'h20, pk(0,0,0,0,0,2,0,1,0,0,0,0,0)},
      {7'b0110011, 3'b001, 7'h00, pk(0,0,0,0,0,2,0,5,0,0,0,0,0)},
      {7'b0110011, 3'b101, 7'h20, pk(0,0,0,0,0,2,0,7,0,0,0,0,0)},
      {7'b0110011, 3'b011, 7'h00, pk(0,0,0,0,0,2,0,9,0,0,0,0,0)},
      {7'b0110011, 3'b111, 7'h00, pk(0,0,0,0,0,2,0,2,0,0,0,0,0)},
      {7'b0010011, 3'b000, 7'h20, pk(0,0,0,0,0,2,1,0,0,0,0,0,0)},
      {7'b0010011, 3'b101, 7'h20, pk(0,0,0,0,0,2,1,7,0,0,0,0,0)},
      {7'b0010011, 3'b100, 7'h00, pk(0,0,0,0,0,2,1,4,0,0,0,0,0)},
      {7'b0010011, 3'b010, 7'h00, pk(0,0,0,0,0,2,1,8,0,0,0,0,0)},
      {7'b0110111, 3'b000, 7'h00, pk(0,0,0,0,0,0,1,10,4,0,0,0,0)}
    };
    for (int i = 0; i < 11; i++) begin
      op = tbl[i][37:31];
      f3 = tbl[i][30:28];
      f7 = tbl[i][27:21];
      ready = 1'b1;
      ncm = 0;
      for (int c = 0; c < 4; c++) begin
        #1;
        case (c)
          0:       e = F_RDY;
          1:       e = DEC_B;
          2:       e = tbl[i][20:0];
          default: e = AWB;
        endcase
        checks++;
        if (vh !== e) begin
          errors++;
          $display("FAIL alu_ops[%0d] cycle %0d: got %h exp %h", i, c + 1, vh, e);
        end
        if (h_instr_commit) ncm++;
        tick();
      end
      checks++;
      if (ncm != 1) begin errors++; $display("FAIL alu_ops[%0d] commits: got %0d exp 1", i, ncm); end
    end
  endtask

  task automatic test_mem();
    logic        lrdy [10];
    logic [20:0] lexp [10];
    logic        srdy [5];
    logic [20:0] sexp [5];
    int first_cm;
    lrdy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    lexp = '{F_WAIT, F_WAIT, F_RDY, DEC_B, MA_L, MR, MR, MR, MR, MWB};
    srdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    sexp = '{F_RDY, DEC_B, MA_S, MW_WAIT, MW_RDY};
    op = 7'b0000011;
    f3 = 3'b010;
    f7 = 7'h00;
    first_cm = 0;
    for (int c = 0; c < 10; c++) begin
      ready = lrdy[c];
      #1;
      checks++;
      if (vh !== lexp[c]) begin
        errors++;
        $display("FAIL load cycle %0d: got %h exp %h", c + 1, vh, lexp[c]);
      end
      if (h_instr_commit && first_cm == 0) first_cm = c + 1;
      tick();
    end
    checks++;
    if (first_cm != 10) begin errors++; $display("FAIL load_commit_cycle: got %0d exp 10", first_cm); end
    op = 7'b0100011;
    for (int c = 0; c < 5; c++) begin
      ready = srdy[c];
      #1;
      checks++;
      if (vh !== sexp[c]) begin
        errors++;
        $display("FAIL store cycle %0d: got %h exp %h", c + 1, vh, sexp[c]);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    logic [24:0] tbl [6];
    logic [20:0] e;
    tbl = '{
      {3'b000, 1'b1, pk(0,0,0,0,1,2,0,1,0,0,0,1,0)},
      {3'b001, 1'b1, pk(0,0,0,0,0,2,0,1,0,0,0,1,0)},
      {3'b100, 1'b0, pk(0,0,0,0,1,2,0,8,0,0,0,1,0)},
      {3'b111, 1'b0, pk(0,0,0,0,0,2,0,9,0,0,0,1,0)},
      {3'b110, 1'b0, pk(0,0,0,0,1,2,0,9,0,0,0,1,0)},
      {3'b101, 1'b1, pk(0,0,0,0,1,2,0,8,0,0,0,1,0)}
    };
    op = 7'b1100011;
    f7 = 7'h00;
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      f3 = tbl[i][24:22];
      zero = tbl[i][21];
      for (int c = 0; c < 3; c++) begin
        #1;
        case (c)
          0:       e = F_RDY;
          1:       e = DEC_B;
          default: e = tbl[i][20:0];
        endcase
        checks++;
        if (vh !== e) begin
          errors++;
          $display("FAIL branch[%0d] cycle %0d: got %h exp %h", i, c + 1, vh, e);
        end
        tick();
      end
    end
    zero = 1'b0;
    #1;
    checks++;
    if (vh !== F_RDY) begin errors++; $display("FAIL branch_back_to_fetch: got %h exp %h", vh, F_RDY); end
  endtask

  task automatic test_jumps();
    logic [20:0] jexp [4];
    logic [20:0] rexp [4];
    jexp = '{F_RDY, DEC_J, pk(0,0,0,0,1,0,0,0,0,0,0,0,0), LINKV};
    rexp = '{F_RDY, DEC_B, pk(0,0,0,0,1,2,1,0,0,0,2,0,0), LINKV};
    ready = 1'b1;
    f3 = 3'b000;
    op = 7'b1101111;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (vh !== jexp[c]) begin errors++; $display("FAIL jal cycle %0d: got %h exp %h", c + 1, vh, jexp[c]); end
      tick();
    end
    op = 7'b1100111;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (vh !== rexp[c]) begin errors++; $display("FAIL jalr cycle %0d: got %h exp %h", c + 1, vh, rexp[c]); end
      tick();
    end
  endtask

  task automatic test_trap_halt();
    op = 7'h7F;
    f3 = 3'b000;
    f7 = 7'h00;
    ready = 1'b1;
    #1;
    checks++;
    if (vh !== F_RDY) begin errors++; $display("FAIL trap_fetch: got %h exp %h", vh, F_RDY); end
    tick();
    checks++;
    if (vh !== DEC_B) begin errors++; $display("FAIL trap_decode: got %h exp %h", vh, DEC_B); end
    tick();
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (vh !== ILL) begin errors++; $display("FAIL trap_hold cycle %0d: got %h exp %h", c, vh, ILL); end
      tick();
    end
    reset = 1'b1;
    ready = 1'b0;
    #1;
    checks++;
    if (vh !== 21'd0) begin errors++; $display("FAIL trap_reset_forced: got %h exp %h", vh, 21'd0); end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (vh !== F_WAIT) begin errors++; $display("FAIL trap_cleared: got %h exp %h", vh, F_WAIT); end
  endtask

  task automatic test_trap_skip();
    logic [20:0] e [7];
    e = '{F_RDY, DEC_B, ILL, F_RDY | ILL, DEC_B | ILL, ILL, F_WAIT | ILL};
    op = 7'b0110011;
    f3 = 3'b000;
    f7 = 7'h01;
    ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c == 3) begin op = 7'b1100011; f3 = 3'b010; f7 = 7'h00; end
      if (c == 6) ready = 1'b0;
      #1;
      checks++;
      if (vs !== e[c]) begin errors++; $display("FAIL trap_skip cycle %0d: got %h exp %h", c + 1, vs, e[c]); end
      tick();
    end
    checks++;
    if (vh !== ILL) begin errors++; $display("FAIL trap_skip_halt_peer: got %h exp %h", vh, ILL); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    op = 7'b0100011;
    f3 = 3'b010;
    f7 = 7'h00;
    ready = 1'b1;
    #1;
    checks++;
    if (vs !== F_RDY) begin errors++; $display("FAIL rmw_fetch: got %h exp %h", vs, F_RDY); end
    tick();
    tick();
    tick();
    ready = 1'b0;
    #1;
    checks++;
    if (vs !== MW_WAIT) begin errors++; $display("FAIL rmw_wait1: got %h exp %h", vs, MW_WAIT); end
    tick();
    checks++;
    if (vs !== MW_WAIT) begin errors++; $display("FAIL rmw_wait2: got %h exp %h", vs, MW_WAIT); end
    reset = 1'b1;
    ready = 1'b1;
    #1;
    checks++;
    if (vs !== 21'd0) begin errors++; $display("FAIL rmw_reset_no_commit: got %h exp %h", vs, 21'd0); end
    tick();
    checks++;
    if (vs !== 21'd0 || vh !== 21'd0) begin
      errors++;
      $display("FAIL rmw_after_edge: got %h/%h exp 0/0", vs, vh);
    end
    reset = 1'b0;
    ready = 1'b0;
    #1;
    checks++;
    if (vs !== F_WAIT) begin errors++; $display("FAIL rmw_refetch: got %h exp %h", vs, F_WAIT); end
  endtask

  initial begin
    F_RDY   = pk(1,0,0,1,1,0,2,0,0,0,2,0,0);
    F_WAIT  = pk(1,0,0,0,0,0,2,0,0,0,2,0,0);
    DEC_B   = pk(0,0,0,0,0,1,1,0,2,0,0,0,0);
    DEC_J   = pk(0,0,0,0,0,1,1,0,3,0,0,0,0);
    AWB     = pk(0,0,0,0,0,0,0,0,0,1,0,1,0);
    LINKV   = pk(0,0,0,0,0,1,2,0,0,1,2,1,0);
    ILL     = pk(0,0,0,0,0,0,0,0,0,0,0,0,1);
    MA_L    = pk(0,0,0,0,0,2,1,0,0,0,0,0,0);
    MA_S    = pk(0,0,0,0,0,2,1,0,1,0,0,0,0);
    MR      = pk(1,0,1,0,0,0,0,0,0,0,0,0,0);
    MWB     = pk(0,0,0,0,0,0,0,0,0,1,1,1,0);
    MW_WAIT = pk(1,1,1,0,0,0,0,0,0,0,0,0,0);
    MW_RDY  = pk(1,1,1,0,0,0,0,0,0,0,0,1,0);
    test_reset();
    test_alu_ops();
    test_mem();
    test_branch();
    test_jumps();
    test_trap_halt();
    test_trap_skip();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle control unit for the next-generation RV32I core, replacing the single-cycle control path so that one shared memory port serves instruction fetch and data access. It sequences each instruction through a state machine, drives the data path's muxes, ALU, register-file and memory controls, and stalls on a ready handshake from memory. Illegal encodings raise a trap flag. A parameter selects whether the core halts or skips the instruction on a trap.

## Interface
- OP_CODE_WIDTH, 7, opcode field width
- FUNCT3_WIDTH, 3, funct3 field width
- FUNCT7_WIDTH, 7, funct7 field width
- ALU_OP_WIDTH, 4, ALU op width. Encoding: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 SRA=7 SLT=8 SLTU=9 PASS_B=10
- TRAP_HALT, 1, 1: park in TRAP until reset; 0: leave TRAP to FETCH after one cycle
- i_clk  in  1  clock; all state changes on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_op_code / i_funct3 / i_funct7  in  7/3/7  fields from the instruction register
- i_alu_zero_flag  in  1  ALU result == 0
- i_mem_ready  in  1  memory completes the current request this cycle
- o_mem_req  out  1  memory access request
- o_mem_wr_en  out  1  request is a write
- o_adr_src  out  1  memory address source: 0 = PC, 1 = ALUOut
- o_ir_wr_en  out  1  load the instruction register and the oldPC register
- o_pc_wr_en  out  1  load the PC
- o_alu_src_a  out  2  0 = PC, 1 = oldPC, 2 = rs1
- o_alu_src_b  out  2  0 = rs2, 1 = immediate, 2 = constant 4
- o_alu_op  out  ALU_OP_WIDTH  ALU operation
- o_imm_sel  out  3  immediate type: 0 = I, 1 = S, 2 = B, 3 = J, 4 = U
- o_reg_file_wr_en  out  1  register-file write
- o_wb_result_sel  out  2  result bus: 0 = ALUOut register, 1 = memory data, 2 = ALU result direct
- o_instr_commit  out  1  one-cycle pulse when an instruction retires
- o_illegal_instr  out  1  sticky trap flag

## Operation
- Outputs not listed for a state are 0.
- **FETCH**
  - Drives o_mem_req=1, adr_src=0.
  - Stays in FETCH while !i_mem_ready.
  - On the cycle i_mem_ready is high: ir_wr_en=1 and pc_wr_en=1, with ALU=PC+4 (src_a=0, src_b=2, ADD, wb_sel=2). Next state DECODE.
- **DECODE**
  - ALU computes oldPC+imm (src_a=1, src_b=1, ADD, wb_sel n/a). imm_sel = J for opcode 1101111, B otherwise.
  - Next-state by opcode:
    - 0000011 or 0100011 → MEM_ADDR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1101111 → JAL
    - 1100111 → JALR
    - 1100011 → BRANCH
    - 0110111 → LUI
    - any other opcode → TRAP
  - An R-type with funct7 ∉ {0x00, 0x20}, or with 0x20 on funct3 other than 000/101, also goes to TRAP.
- **MEM_ADDR**
  - rs1+imm (src_a=2, src_b=1, ADD); imm_sel = I for loads, S for stores.
  - Loads go to MEM_READ, stores to MEM_WRITE.
- **MEM_READ**
  - mem_req=1, adr_src=1.
  - Waits for ready, then goes to MEM_WB.
- **MEM_WB**
  - reg_wr=1, wb_sel=1, commit=1.
  - Next state FETCH.
- **MEM_WRITE**
  - mem_req=1, mem_wr_en=1, adr_src=1.
  - On ready: commit=1, next state FETCH.
- **EXEC_R**
  - src_a=2, src_b=0.
  - alu_op from funct3: 000 → ADD/SUB by funct7[5], 001 → SLL, 010 → SLT, 011 → SLTU, 100 → XOR, 101 → SRL/SRA by funct7[5], 110 → OR, 111 → AND.
  - Next state ALU_WB.
- **EXEC_I**
  - As EXEC_R, with src_b=1 and imm_sel=I.
  - funct3 000 is always ADD.
  - Next state ALU_WB.
- **LUI**
  - src_b=1, imm_sel=U, PASS_B.
  - Next state ALU_WB.
- **ALU_WB**
  - reg_wr=1, wb_sel=0, commit=1.
  - Next state FETCH.
- **JAL**
  - pc_wr_en=1, wb_sel=0 (PC ← target held in ALUOut).
  - Next state LINK.
- **JALR**
  - src_a=2, src_b=1, imm_sel=I, ADD, pc_wr_en=1, wb_sel=2.
  - Next state LINK.
- **LINK**
  - oldPC+4 (src_a=1, src_b=2, ADD), reg_wr=1, wb_sel=2, commit=1.
  - Next state FETCH.
- **BRANCH**
  - src_a=2, src_b=0, wb_sel=0, commit=1. Next state FETCH.
  - alu_op by funct3: 000/001 → SUB, 100/101 → SLT, 110/111 → SLTU.
  - pc_wr_en = taken, where taken = (000 & Z) | (001 & !Z) | (100 & !Z) | (101 & Z) | (110 & !Z) | (111 & Z).
  - funct3 010/011 → TRAP instead.
- **TRAP**
  - o_illegal_instr set on entry and held until i_reset; no commit is issued.
  - TRAP_HALT=1: remains in TRAP.
  - TRAP_HALT=0: goes to FETCH next cycle. PC already holds PC+4, so the instruction is skipped.

## Timing
- Reset:
  - While i_reset=1: state ← FETCH, o_illegal_instr ← 0, all outputs forced to 0 (including o_mem_req).
  - First cycle after release: FETCH with o_mem_req=1.
  - Reset asserted in any state, including a memory wait, aborts the instruction at the next edge. No commit pulse is produced.
- Outputs are decoded combinationally from the state register.
  - FETCH ir/pc enables and the MEM_WRITE commit are additionally gated by i_mem_ready.
- Latency with zero-wait memory:
  - branch: 3 cycles
  - store, R, I, LUI, JAL, JALR: 4 cycles
  - load: 5 cycles
  - Each cycle i_mem_ready is low in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- Handshake:
  - o_mem_req, o_adr_src and o_mem_wr_en are stable for the whole wait.
  - The request ends the cycle after ready is sampled.
  - i_mem_ready is ignored when o_mem_req=0.
- o_instr_commit: exactly one pulse per retired instruction, asserted in the final state. It is never high in two consecutive cycles.

## Test plan
- add x3,x1,x2 with ready tied high → state sequence FETCH, DECODE, EXEC_R, ALU_WB; alu_op=0 then reg_wr=1, wb_sel=0; commit on cycle 4.
- lw with ready low for 2 cycles in FETCH and 3 in MEM_READ → o_mem_req held, adr_src 0 then 1; commit on cycle 10; reg_wr with wb_sel=1.
- beq with Z=1, then bne with Z=1 → pc_wr_en=1 for the first, 0 for the second; each completes in 3 cycles with one commit.
- jalr x1,0(x5) → JALR state pc_wr_en=1, wb_sel=2; LINK state reg_wr=1, src_a=1, src_b=2.
- Opcode 0x7F with TRAP_HALT=1 → o_illegal_instr=1, no commit, stays in TRAP for 20 cycles; i_reset clears the flag, then FETCH.
- TRAP_HALT=0, R-type with funct7=0x01 → TRAP for one cycle, then FETCH with the flag still set; reset asserted mid MEM_WRITE wait → no commit and all outputs 0 at the next edge.
